dmem_byte_port: RTL and testbench

Memory-side responder for CPU data-memory accesses. It accepts byte, halfword and word load/store requests from the pipeline's memory stage over a valid/ready handshake. It drives a word-only synchronous single-port data RAM, performing read-modify-write for sub-word stores and lane extraction with sign/zero extension for sub-word loads. It sits between the MEM stage and the data RAM and replaces per-access byte-address conversion done combinationally in the datapath.

---
 rtl/dmem_byte_port_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 40 ++++
 rtl/dmem_byte_port.sv | 137 +++++++++++++
 tb/tb_dmem_byte_port.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_byte_port_pkg.sv
// Shared encodings for the data-memory byte port: access sizes, FSM states
// and the alignment rule used at request acceptance.
package dmem_byte_port_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    DMP_IDLE = 3'd0,
    DMP_RD   = 3'd1,
    DMP_RDW  = 3'd2,
    DMP_WR   = 3'd3,
    DMP_RESP = 3'd4
  } dmp_state_e;

  // Size 11 has no legal encoding, so it is rejected like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      SIZE_WORD: return lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts/extends a sub-word load from a RAM word
// and merges right-justified store data into the selected lane of that word.
module dmem_lane_align
  import dmem_byte_port_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_bit;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bit  = {i_lane, 3'b000};
  assign w_byte = i_word[w_bit +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SIZE_BYTE: begin
        o_load             = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[w_bit +: 8] = i_wdata[7:0];
      end
      SIZE_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_lane[1]) o_merged[31:16] = i_wdata;
        else           o_merged[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_byte_port.sv
// MEM-stage responder for byte/half/word loads and stores against a word-only
// synchronous RAM; sub-word stores go through read-modify-write.
module dmem_byte_port
  import dmem_byte_port_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  dmp_state_e        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_lane;
  logic [15:0]       r_wdata;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic        w_unused;

  assign w_unused = ^req_addr[31:ADDR_W+2];

  assign req_ready  = (r_state == DMP_IDLE) && !rst;
  assign w_err      = is_misaligned(req_size, req_addr[1:0]);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  // Gate the RAM strobes with rst so a reset cycle can never carry a write.
  assign mem_en     = r_mem_en & ~rst;
  assign mem_we     = r_mem_we & ~rst;

  dmem_lane_align u_align (
    .i_word   (mem_rdata),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= DMP_IDLE;
      r_we         <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        DMP_IDLE: if (req_valid) begin
          r_we         <= req_we;
          r_size       <= req_size;
          r_signed     <= req_signed;
          r_lane       <= req_addr[1:0];
          r_wdata      <= req_wdata[15:0];
          r_resp_rdata <= '0;
          r_resp_err   <= w_err;
          if (w_err) begin
            r_resp_valid <= 1'b1;
            r_state      <= DMP_RESP;
          end else begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= req_addr[ADDR_W+1:2];
            // Full-word stores need no read, so they go straight to the write.
            if (req_we && req_size == SIZE_WORD) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= req_wdata;
              r_state     <= DMP_WR;
            end else begin
              r_state <= DMP_RD;
            end
          end
        end
        DMP_RD: begin
          r_mem_en <= 1'b0;
          r_state  <= DMP_RDW;
        end
        DMP_RDW: if (r_we) begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_wdata <= w_merged;
          r_state     <= DMP_WR;
        end else begin
          r_resp_rdata <= w_load;
          r_resp_valid <= 1'b1;
          r_state      <= DMP_RESP;
        end
        DMP_WR: begin
          r_mem_en     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= DMP_RESP;
        end
        DMP_RESP: r_state <= DMP_IDLE;
        default:  r_state <= DMP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_port.sv
// Directed plus randomized bench for dmem_byte_port with a behavioural RAM and
// an arithmetic reference model of loads, stores, alignment and latency.
module tb_dmem_byte_port;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [31:0]       bd_data;
  logic [31:0]       ram     [2**ADDR_W];
  logic [31:0]       ref_mem [2**ADDR_W];

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  dmem_byte_port #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM with a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int lane,
                                           input int nbytes, input logic sg);
    logic [63:0] mask, v;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    v    = ({32'd0, w} >> (8 * lane)) & mask;
    if (sg && nbytes < 4 && v > (mask >> 1)) v = v + (64'h1_0000_0000 - (mask + 64'd1));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int lane,
                                            input int nbytes, input logic [31:0] d);
    logic [63:0] mask, v;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    v    = ({32'd0, w} & ~(mask << (8 * lane))) | (({32'd0, d} & mask) << (8 * lane));
    return v[31:0];
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = ADDR_W'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
    int widx, nbytes, lat, wcyc, exp_en;
    int resp_cyc, n_resp, n_rdy, n_en, n_we, w_seen, rd_cyc;
    logic err;
    logic [31:0] exp_rd, neww, w_data, r_data;
    logic r_err;
    logic [ADDR_W-1:0] acc_addr;
    widx   = int'(addr[ADDR_W+1:2]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err    = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    lat    = err ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 4));
    wcyc   = (we && !err) ? lat - 1 : 0;
    exp_en = err ? 0 : ((we && sz != 2'd2) ? 2 : 1);
    exp_rd = (!we && !err) ? ref_load(ref_mem[widx], int'(addr[1:0]), nbytes, sg) : 32'd0;
    neww   = (we && !err) ? ref_store(ref_mem[widx], int'(addr[1:0]), nbytes, wd) : ref_mem[widx];
    resp_cyc = 0; n_resp = 0; n_rdy = 0; n_en = 0; n_we = 0; w_seen = 0; rd_cyc = 0;
    w_data = '0; r_data = '0; r_err = 1'b0; acc_addr = '0;

    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      if (mem_en) begin
        n_en++;
        acc_addr = mem_addr;
        if (mem_we) begin n_we++; w_seen = c; w_data = mem_wdata; end
        else rd_cyc = c;
      end
      if (resp_valid) begin
        n_resp++;
        if (resp_cyc == 0) begin resp_cyc = c; r_data = resp_rdata; r_err = resp_err; end
      end
      if (c <= lat && req_ready) n_rdy++;
    end
    chk("resp_cycle", 32'(resp_cyc), 32'(lat));
    chk("resp_pulses", 32'(n_resp), 32'd1);
    chk("resp_err", {31'd0, r_err}, {31'd0, err});
    chk("resp_rdata", r_data, exp_rd);
    chk("busy_ready", 32'(n_rdy), 32'd0);
    chk("mem_en_cycles", 32'(n_en), 32'(exp_en));
    chk("write_cycle", 32'(w_seen), 32'(wcyc));
    chk("write_count", 32'(n_we), (wcyc != 0) ? 32'd1 : 32'd0);
    if (!err) chk("mem_addr", 32'(acc_addr), 32'(widx));
    if (!we && !err) chk("read_cycle", 32'(rd_cyc), 32'd1);
    if (wcyc != 0) chk("mem_wdata", w_data, neww);
    chk("ram_word", ram[widx], neww);
    ref_mem[widx] = neww;
    last_rdata = r_data;
  endtask

  initial begin
    int n_bad_rst, n_we_rst, n_rv_rst;
    logic [1:0]  rsz;
    logic [31:0] raddr;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Reset: two cycles with everything quiet, ready one cycle after release.
    n_bad_rst = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (req_ready || mem_en || resp_valid) n_bad_rst++;
    end
    chk("reset_quiet", 32'(n_bad_rst), 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", {31'd0, resp_err}, 32'd0);
    chk("reset_memwe", {31'd0, mem_we}, 32'd0);
    chk("reset_memaddr", 32'(mem_addr), 32'd0);
    chk("reset_memwdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Byte loads.
    poke(4, 32'h8081_7F80);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0); chk("ldb_s_11", last_rdata, 32'h0000_007F);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0); chk("ldb_s_12", last_rdata, 32'hFFFF_FF81);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0); chk("ldb_u_12", last_rdata, 32'h0000_0081);

    // Stores: byte RMW, half RMW, signed half read-back, word store.
    poke(4, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB); chk("stb_ram", ram[4], 32'hAB22_3344);
    poke(4, 32'h1122_3344);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF); chk("sth_ram", ram[4], 32'hBEEF_3344);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);         chk("ldh_s", last_rdata, 32'hFFFF_BEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF); chk("stw_ram", ram[4], 32'hDEAD_BEEF);

    // Misaligned requests.
    do_req(1'b0, 2'd2, 1'b0, 32'h16, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234_5678);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);

    // Reset during the merge cycle of a byte store.
    poke(4, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h13; req_wdata = 32'hAB;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_we_rst = 0; n_rv_rst = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_we) n_we_rst++;
      if (resp_valid) n_rv_rst++;
      @(negedge clk);
      if (c == 1) rst = 1'b0;
    end
    chk("rst_mid_we", 32'(n_we_rst), 32'd0);
    chk("rst_mid_resp", 32'(n_rv_rst), 32'd0);
    chk("rst_mid_ram", ram[4], 32'h1122_3344);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0); chk("ld_after_rst", last_rdata, 32'h0000_0011);

    // Randomized traffic over a small window so stores and loads collide.
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    for (int i = 0; i < 150; i++) begin
      rsz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      raddr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) raddr[0] = 1'b0;
        if (rsz == 2'd2) raddr[1:0] = 2'b00;
      end
      do_req(1'($urandom), rsz, 1'($urandom), raddr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
